mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller. Takes load/store requests from the EX/MEM register and runs one transaction per request on the data bus.
- For stores, aligns write data and generates byte strobes. For loads, returns the raw read word plus the 4-bit load-extension code consumed directly by the downstream load-extension stage.
- Detects misaligned addresses (AdEL/AdES) and bus timeouts, and reports them to the exception unit.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 255: maximum BUS-state cycles without bus_ready before a bus-error exception is raised.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage holds a load/store.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend the load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- flush  in  1  exception/ERET flush; cancels the access.
- stall  out  1  hold IF..MEM stages.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  raw read word, valid with done.
- be_out  out  4  extension code, valid with done on loads.
- exc_adel  out  1  load address error pulse.
- exc_ades  out  1  store address error pulse.
- exc_dbe  out  1  bus timeout error pulse.
- exc_badvaddr  out  32  faulting address.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, with bits [1:0] = 00.
- bus_wstrb  out  4  byte write strobes.
- bus_wdata  out  32  replicated store data.
- bus_ready  in  1  bus transaction complete.
- bus_rdata  in  32  bus read data.

Behaviour:
- Reset: state IDLE, counter 0, every output 0.
- States: IDLE, BUS, RESP, EXC.
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always misaligned.
- IDLE:
  - req_valid and aligned: latch request, go to BUS.
  - req_valid and misaligned: latch addr and we, go to EXC.
- BUS:
  - bus_req=1; bus_addr={addr[31:2],2'b00}.
  - bus_we and bus_wstrb come from the latched request.
  - Counter increments each cycle.
  - bus_ready: capture bus_rdata into rdata, go to RESP.
  - counter==TIMEOUT with no bus_ready: drop bus_req, go to EXC with dbe cause.
- RESP: done=1 for one cycle, then IDLE. req_valid is ignored in this cycle, because it is the same instruction advancing.
- EXC: exactly one of exc_adel/exc_ades/exc_dbe is 1 for one cycle; exc_badvaddr = latched addr; then IDLE.
- stall = (IDLE & req_valid) | BUS. stall is 0 in RESP and EXC.
- Latency: minimum 3 cycles from req_valid to done (IDLE, BUS with immediate bus_ready, RESP).
- Store wstrb by size and address:
  - byte: 0001 << addr[1:0]
  - half: 0011 (addr[1]=0) or 1100 (addr[1]=1)
  - word: 1111
- Store wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Loads drive bus_wstrb=0.
- be_out on loads: {req_signed, code}, with code values:
  - BYTE0=000, BYTE1=001, BYTE2=010, BYTE3=011 (byte loads, selected by addr[1:0])
  - HALF0=100, HALF1=101 (half loads, selected by addr[1])
  - WORD=110
- be_out on stores: 0000.
- flush: highest priority in every state. Next state is IDLE; bus_req drops the same cycle (combinational gate); no done or exception pulse. A bus_ready arriving in or after a flushed cycle is ignored. The bus treats bus_req deassertion as abandonment.
- Bus outputs are 0 outside BUS.
- The requester holds req_* stable while stall=1.
- Simultaneous bus_ready and counter==TIMEOUT: bus_ready wins, go to RESP.

Test Plan:
- Word load at addr 0x1000, bus_ready on the 2nd BUS cycle with rdata 0xDEADBEEF -> bus_addr 0x1000, wstrb 0000. Then done=1 with rdata 0xDEADBEEF, be_out 0110. stall high for exactly 3 cycles.
- Signed byte load at 0x1003 -> be_out 1011, bus_addr 0x1000, one done pulse. Unsigned half load at 0x1002 -> be_out 0101.
- Half store of 0x0000ABCD at 0x2002 -> bus_we 1, wstrb 1100, wdata 0xABCDABCD. Byte store of 0x77 at 0x2001 -> wstrb 0010, wdata 0x77777777.
- Word load at 0x1002 -> no bus_req; exc_adel pulse; exc_badvaddr 0x1002. Half store at 0x3001 -> exc_ades. Size 11 -> exception.
- bus_ready never asserted (TIMEOUT=4) -> bus_req for 5 cycles, then exc_dbe pulse and return to IDLE. Variant: bus_ready on the timeout cycle -> done, no exc_dbe.
- flush in the 2nd BUS cycle -> bus_req low the same cycle; late bus_ready ignored; no done. Variant: rstn low mid-BUS -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-bus signal bundle between the MEM-stage access controller (master)
// and the data memory / bus fabric (slave).
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one bus transaction per load/store,
// store alignment/strobes, load-extension code, AdEL/AdES/DBE reporting, stall.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [3:0]  be_out,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_dbe,
  output logic [31:0] exc_badvaddr,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, EXC} state_t;

  state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic        we_q, sgn_q, dbe_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        misaligned, timeout_hit;
  logic [3:0]  strb, code;
  logic [31:0] wdata_rep;

  assign misaligned  = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (|req_addr[1:0]));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      dbe_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wdata_q <= req_wdata;
            dbe_q   <= 1'b0;
            cnt     <= '0;
          end
        end
        BUS: begin
          if (!flush) begin
            cnt <= cnt + CNT_W'(1);
            if (bus.bus_ready) rdata <= bus.bus_rdata;
            dbe_q <= timeout_hit & ~bus.bus_ready;
          end
        end
        default: ;
      endcase
    end
  end

  // Store lane steering and load-extension code, all from the latched request
  always_comb begin
    strb      = '0;
    wdata_rep = '0;
    code      = '0;
    if (we_q) begin
      case (size_q)
        2'b00: begin
          strb      = 4'b0001 << addr_q[1:0];
          wdata_rep = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          strb      = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata_q[15:0]}};
        end
        2'b10: begin
          strb      = 4'b1111;
          wdata_rep = wdata_q;
        end
        default: ;
      endcase
    end else begin
      case (size_q)
        2'b00:   code = {sgn_q, 1'b0, addr_q[1:0]};
        2'b01:   code = {sgn_q, 2'b10, addr_q[1]};
        default: code = {sgn_q, 3'b110};
      endcase
    end
  end

  always_comb begin
    state_nx          = state;
    stall             = 1'b0;
    done              = 1'b0;
    be_out            = '0;
    exc_adel          = 1'b0;
    exc_ades          = 1'b0;
    exc_dbe           = 1'b0;
    exc_badvaddr      = '0;
    bus.bus_req       = 1'b0;
    bus.bus_we        = 1'b0;
    bus.bus_addr      = '0;
    bus.bus_wstrb     = '0;
    bus.bus_wdata     = '0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) state_nx = misaligned ? EXC : BUS;
      end
      BUS: begin
        stall         = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = {addr_q[31:2], 2'b00};
        bus.bus_wstrb = strb;
        bus.bus_wdata = wdata_rep;
        if (bus.bus_ready)    state_nx = RESP;
        else if (timeout_hit) state_nx = EXC;
      end
      RESP: begin
        done     = 1'b1;
        be_out   = code;
        state_nx = IDLE;
      end
      EXC: begin
        exc_dbe      = dbe_q;
        exc_adel     = ~dbe_q & ~we_q;
        exc_ades     = ~dbe_q & we_q;
        exc_badvaddr = addr_q;
        state_nx     = IDLE;
      end
    endcase
    // Flush overrides everything except the stall equation
    if (flush) begin
      state_nx      = IDLE;
      done          = 1'b0;
      be_out        = '0;
      exc_adel      = 1'b0;
      exc_ades      = 1'b0;
      exc_dbe       = 1'b0;
      exc_badvaddr  = '0;
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wstrb = '0;
      bus.bus_wdata = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: per-cycle expectations are generated
// from transaction-level rules and checked by a single compare process.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, exc_adel, exc_ades, exc_dbe;
  logic [31:0] rdata, exc_badvaddr;
  logic [3:0]  be_out;

  mem_access_ctrl_if bif ();

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .stall(stall), .done(done), .rdata(rdata), .be_out(be_out),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_dbe(exc_dbe),
    .exc_badvaddr(exc_badvaddr), .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall, done, adel, ades, dbe, bus_req, bus_we, chk_rd;
    logic [31:0] rdata, badv, bus_addr, bus_wdata;
    logic [3:0]  be, wstrb;
  } exp_t;

  exp_t expq[$];
  exp_t ce;
  int vectors = 0;
  int miscompares = 0;

  int n_stall, n_done, n_breq, n_adel, n_ades, n_dbe;
  logic [31:0] o_rdata, o_addr, o_wdata, o_badv;
  logic [3:0]  o_be, o_wstrb;
  logic        o_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    chk(nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      ce = expq.pop_front();
      vectors++;
      chk("stall", 32'(stall), 32'(ce.stall));
      chk("done", 32'(done), 32'(ce.done));
      chk("be_out", 32'(be_out), 32'(ce.be));
      chk("exc_adel", 32'(exc_adel), 32'(ce.adel));
      chk("exc_ades", 32'(exc_ades), 32'(ce.ades));
      chk("exc_dbe", 32'(exc_dbe), 32'(ce.dbe));
      chk("exc_badvaddr", exc_badvaddr, ce.badv);
      chk("bus_req", 32'(bif.bus_req), 32'(ce.bus_req));
      chk("bus_we", 32'(bif.bus_we), 32'(ce.bus_we));
      chk("bus_addr", bif.bus_addr, ce.bus_addr);
      chk("bus_wstrb", 32'(bif.bus_wstrb), 32'(ce.wstrb));
      chk("bus_wdata", bif.bus_wdata, ce.bus_wdata);
      if (ce.chk_rd) chk("rdata", rdata, ce.rdata);
    end
    if (stall) n_stall++;
    if (done) begin n_done++; o_rdata = rdata; o_be = be_out; end
    if (bif.bus_req) begin
      n_breq++; o_addr = bif.bus_addr; o_wstrb = bif.bus_wstrb;
      o_wdata = bif.bus_wdata; o_we = bif.bus_we;
    end
    if (exc_adel) n_adel++;
    if (exc_ades) n_ades++;
    if (exc_dbe)  n_dbe++;
    if (exc_adel | exc_ades | exc_dbe) o_badv = exc_badvaddr;
  end

  task automatic obs_clear();
    n_stall = 0; n_done = 0; n_breq = 0; n_adel = 0; n_ades = 0; n_dbe = 0;
    o_rdata = '0; o_addr = '0; o_wdata = '0; o_badv = '0; o_be = '0; o_wstrb = '0; o_we = 1'b0;
  endtask

  // Reference rules, stated in bytes-per-access arithmetic
  function automatic logic misal(input logic [1:0] size, input logic [31:0] a);
    int n;
    if (size == 2'd3) return 1'b1;
    n = 1 << size;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] f_strb(input logic we, input logic [1:0] size, input logic [31:0] a);
    int n, off;
    if (!we) return 4'h0;
    n   = 1 << size;
    off = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] f_wdata(input logic we, input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    int n;
    if (!we) return 32'h0;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] f_code(input logic we, input logic [1:0] size, input logic sgn,
                                        input logic [31:0] a);
    int c;
    if (we) return 4'h0;
    c = (size == 2'd0) ? int'(a[1:0]) : (size == 2'd1) ? 4 + int'(a[1:0]) / 2 : 6;
    return 4'(c + (sgn ? 8 : 0));
  endfunction

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = '0;
      step(e);
    end
  endtask

  task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rd, input int flush_at);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd; flush = 1'b0; bif.bus_ready = 1'b0;
    e = '0; e.stall = 1'b1;
    step(e);
    if (misal(size, addr)) begin
      req_valid = 1'b0;
      e = '0; e.adel = ~we; e.ades = we; e.badv = addr;
      step(e);
      return;
    end
    for (int k = 0; k <= TO; k++) begin
      bif.bus_ready = (k == delay);
      bif.bus_rdata = (k == delay) ? rd : $urandom;
      flush = (k == flush_at);
      e = '0; e.stall = 1'b1;
      if (!flush) begin
        e.bus_req = 1'b1; e.bus_we = we; e.bus_addr = {addr[31:2], 2'b00};
        e.wstrb = f_strb(we, size, addr); e.bus_wdata = f_wdata(we, size, wd);
      end
      step(e);
      if (k == flush_at) begin
        flush = 1'b0; req_valid = 1'b0; bif.bus_ready = 1'b1; bif.bus_rdata = $urandom;
        e = '0;
        step(e);
        bif.bus_ready = 1'b0;
        return;
      end
      if (k == delay) break;
      if (k == TO) begin
        bif.bus_ready = 1'b0; req_valid = 1'b0;
        e = '0; e.dbe = 1'b1; e.badv = addr;
        step(e);
        return;
      end
    end
    bif.bus_ready = 1'b0;
    e = '0; e.done = 1'b1; e.chk_rd = 1'b1; e.rdata = rd; e.be = f_code(we, size, sgn, addr);
    step(e);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic        t_we, t_sgn;
    logic [1:0]  t_size;
    logic [31:0] t_addr;
    int          t_fl;

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    bif.bus_ready = 1'b0; bif.bus_rdata = '0;
    obs_clear();
    @(posedge clk); #1;
    e = '0; e.chk_rd = 1'b1;
    step(e); step(e);
    rstn = 1'b1;
    step(e);

    obs_clear();
    do_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1, 32'hDEADBEEF, -1);
    lit("wl_addr", o_addr, 32'h1000);
    lit("wl_wstrb", 32'(o_wstrb), 32'h0);
    lit("wl_ndone", n_done, 1);
    lit("wl_rdata", o_rdata, 32'hDEADBEEF);
    lit("wl_be", 32'(o_be), 32'h6);
    lit("wl_nstall", n_stall, 3);

    obs_clear();
    do_txn(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 32'h11223344, -1);
    lit("sb_be", 32'(o_be), 32'hB);
    lit("sb_addr", o_addr, 32'h1000);
    lit("sb_ndone", n_done, 1);
    obs_clear();
    do_txn(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 0, 32'h55667788, -1);
    lit("uh_be", 32'(o_be), 32'h5);

    obs_clear();
    do_txn(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 0, 32'h0, -1);
    lit("hs_we", 32'(o_we), 32'h1);
    lit("hs_wstrb", 32'(o_wstrb), 32'hC);
    lit("hs_wdata", o_wdata, 32'hABCDABCD);
    lit("hs_be", 32'(o_be), 32'h0);
    obs_clear();
    do_txn(1'b1, 2'd0, 1'b0, 32'h2001, 32'h00000077, 0, 32'h0, -1);
    lit("bs_wstrb", 32'(o_wstrb), 32'h2);
    lit("bs_wdata", o_wdata, 32'h77777777);

    obs_clear();
    do_txn(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 0, 32'h0, -1);
    lit("adel_nbreq", n_breq, 0);
    lit("adel_n", n_adel, 1);
    lit("adel_badv", o_badv, 32'h1002);
    obs_clear();
    do_txn(1'b1, 2'd1, 1'b0, 32'h3001, 32'h1234, 0, 32'h0, -1);
    lit("ades_n", n_ades, 1);
    lit("ades_badv", o_badv, 32'h3001);
    obs_clear();
    do_txn(1'b0, 2'd3, 1'b0, 32'h5000, 32'h0, 0, 32'h0, -1);
    lit("sz3_nadel", n_adel, 1);
    lit("sz3_nbreq", n_breq, 0);

    obs_clear();
    do_txn(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 99, 32'h0, -1);
    idle(1);
    lit("to_nbreq", n_breq, 5);
    lit("to_ndbe", n_dbe, 1);
    lit("to_ndone", n_done, 0);
    lit("to_badv", o_badv, 32'h6000);
    obs_clear();
    do_txn(1'b0, 2'd2, 1'b0, 32'h6004, 32'h0, TO, 32'hCAFEF00D, -1);
    lit("tob_ndone", n_done, 1);
    lit("tob_ndbe", n_dbe, 0);
    lit("tob_rdata", o_rdata, 32'hCAFEF00D);

    obs_clear();
    do_txn(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 2, 32'h12345678, 1);
    idle(2);
    lit("fl_nbreq", n_breq, 1);
    lit("fl_ndone", n_done, 0);

    // Asynchronous reset in the middle of a bus transaction
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4000; flush = 1'b0;
    bif.bus_ready = 1'b0;
    e = '0; e.stall = 1'b1;
    step(e);
    e = '0; e.stall = 1'b1; e.bus_req = 1'b1; e.bus_addr = 32'h4000;
    step(e);
    e = '0; e.chk_rd = 1'b1;
    expq.push_back(e);
    #2 rstn = 1'b0; req_valid = 1'b0;
    #1;
    lit("rst_bus_req", 32'(bif.bus_req), 32'h0);
    lit("rst_bus_addr", bif.bus_addr, 32'h0);
    lit("rst_stall", 32'(stall), 32'h0);
    lit("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    step(e);
    rstn = 1'b1;
    idle(1);

    for (int t = 0; t < 300; t++) begin
      t_we   = 1'($urandom_range(1));
      t_size = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
      t_sgn  = 1'($urandom_range(1));
      t_addr = $urandom;
      if ($urandom_range(3) != 0 && t_size != 2'd3) begin
        if (t_size == 2'd1) t_addr[0] = 1'b0;
        if (t_size == 2'd2) t_addr[1:0] = 2'b00;
      end
      t_fl = ($urandom_range(7) == 0) ? int'($urandom_range(2)) : -1;
      do_txn(t_we, t_size, t_sgn, t_addr, $urandom, int'($urandom_range(6)), $urandom, t_fl);
      idle(int'($urandom_range(2)));
    end

    idle(1);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
